// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder_if
// Description : Request/response bundle between a load/store initiator and
//               the data memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_responder_if;
  logic        write_word_en;
  logic        write_byte_en;
  logic        read_word_en;
  logic        read_byte_en;
  logic [31:0] write_word_address;
  logic [31:0] write_byte_address;
  logic [31:0] read_word_address;
  logic [31:0] read_byte_address;
  logic [31:0] write_word_data;
  logic [7:0]  write_byte_data;
  logic [31:0] read_word_data;
  logic [7:0]  read_byte_data;
  logic        busy;
  logic        done;
  logic        err;

  // Initiator side: issues requests, observes results.
  modport master (
    output write_word_en, write_byte_en, read_word_en, read_byte_en,
    output write_word_address, write_byte_address,
    output read_word_address, read_byte_address,
    output write_word_data, write_byte_data,
    input  read_word_data, read_byte_data, busy, done, err
  );

  // Responder side: serves requests.
  modport slave (
    input  write_word_en, write_byte_en, read_word_en, read_byte_en,
    input  write_word_address, write_byte_address,
    input  read_word_address, read_byte_address,
    input  write_word_data, write_byte_data,
    output read_word_data, read_byte_data, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Word/byte load-store responder over a single-port word RAM
//               with registered read. Byte stores are read-modify-write.
//               Little-endian byte lanes; misaligned word loads rotate.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_mem_responder_if.slave  bus
);

  localparam int c_idx_w = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RD     = 2'd1,
    S_RMW_RD = 2'd2,
    S_RMW_WR = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic [31:0]        r_rdw;
  logic [7:0]         r_rdb;
  logic [c_idx_w-1:0] r_idx;
  logic [1:0]         r_lane;
  logic               r_oor;
  logic               r_is_byte;
  logic [7:0]         r_wbyte;

  logic [31:0]        r_mem [DEPTH_WORDS];
  logic [31:0]        r_ram_q;

  logic               w_idle;
  logic               w_acc_ww;
  logic               w_acc_wb;
  logic               w_acc_rw;
  logic               w_acc_rb;
  logic               w_any;
  logic [31:0]        w_sel_addr;
  logic               w_sel_oor;
  logic [c_idx_w-1:0] w_sel_idx;
  logic               w_ram_we;
  logic               w_ram_re;
  logic [c_idx_w-1:0] w_ram_idx;
  logic [31:0]        w_ram_wdata;
  logic [31:0]        w_merged;
  logic [31:0]        w_rot;

  // Fixed-priority arbitration; requests only count while idle.
  assign w_idle   = (r_state == S_IDLE);
  assign w_acc_ww = w_idle &  bus.write_word_en;
  assign w_acc_wb = w_idle & ~bus.write_word_en &  bus.write_byte_en;
  assign w_acc_rw = w_idle & ~bus.write_word_en & ~bus.write_byte_en &  bus.read_word_en;
  assign w_acc_rb = w_idle & ~bus.write_word_en & ~bus.write_byte_en & ~bus.read_word_en
                  & bus.read_byte_en;
  assign w_any    = w_acc_ww | w_acc_wb | w_acc_rw | w_acc_rb;

  // Address of the winning request.
  always_comb begin
    w_sel_addr = bus.read_byte_address;
    if (bus.write_word_en)      w_sel_addr = bus.write_word_address;
    else if (bus.write_byte_en) w_sel_addr = bus.write_byte_address;
    else if (bus.read_word_en)  w_sel_addr = bus.read_word_address;
  end

  assign w_sel_oor = ({2'b00, w_sel_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign w_sel_idx = w_sel_addr[c_idx_w+1:2];

  // Byte-lane merge for the write half of a read-modify-write.
  always_comb begin
    w_merged = r_ram_q;
    for (int i = 0; i < 4; i++) begin
      if (r_lane == 2'(i)) w_merged[8*i +: 8] = r_wbyte;
    end
  end

  // Misaligned word loads return the aligned word rotated right by lane bytes;
  // the low byte of the rotated word is also the addressed byte.
  always_comb begin
    case (r_lane)
      2'd1:    w_rot = {r_ram_q[7:0],  r_ram_q[31:8]};
      2'd2:    w_rot = {r_ram_q[15:0], r_ram_q[31:16]};
      2'd3:    w_rot = {r_ram_q[23:0], r_ram_q[31:24]};
      default: w_rot = r_ram_q;
    endcase
  end

  // Single RAM port: word store at accept, RMW write on the final edge. Reset
  // low blocks any write so an interrupted byte store leaves the word intact.
  assign w_ram_we    = rst_n & ((w_acc_ww & ~w_sel_oor) | ((r_state == S_RMW_WR) & ~r_oor));
  assign w_ram_re    = w_acc_rw | w_acc_rb | (r_state == S_RMW_RD);
  assign w_ram_idx   = w_idle ? w_sel_idx : r_idx;
  assign w_ram_wdata = w_idle ? bus.write_word_data : w_merged;

  // RAM array with registered read; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_ram_we) r_mem[w_ram_idx] <= w_ram_wdata;
    if (w_ram_re) r_ram_q <= r_mem[w_ram_idx];
  end

  // Control FSM: accepts one request, sequences it, registers all outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_rdw     <= '0;
      r_rdb     <= '0;
      r_idx     <= '0;
      r_lane    <= '0;
      r_oor     <= 1'b0;
      r_is_byte <= 1'b0;
      r_wbyte   <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_idx     <= w_sel_idx;
            r_lane    <= w_sel_addr[1:0];
            r_oor     <= w_sel_oor;
            r_wbyte   <= bus.write_byte_data;
            r_is_byte <= w_acc_rb;
            if (w_acc_ww) begin
              r_done <= 1'b1;
              r_err  <= w_sel_oor;
            end else if (w_acc_wb) begin
              r_state <= S_RMW_RD;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_RD;
              r_busy  <= 1'b1;
            end
          end
        end
        S_RD: begin
          if (r_is_byte) r_rdb <= r_oor ? 8'h00 : w_rot[7:0];
          else           r_rdw <= r_oor ? 32'h0 : w_rot;
          r_done  <= 1'b1;
          r_err   <= r_oor;
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        S_RMW_RD: begin
          r_state <= S_RMW_WR;
        end
        S_RMW_WR: begin
          r_done  <= 1'b1;
          r_err   <= r_oor;
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.read_word_data = r_rdw;
  assign bus.read_byte_data = r_rdb;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.err            = r_err;

endmodule
`default_nettype wire
